// File: rtl/instruction_fetch_pkg.sv
// Shared constants and state encodings for the instruction-fetch front end.
package instruction_fetch_pkg;

  localparam int          ADDR_W_DEFAULT   = 8;
  localparam int          INSTR_W_DEFAULT  = 16;
  localparam int unsigned RESET_PC_DEFAULT = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_HALTED
  } if_state_e;

  // Source of the next program-counter value.
  typedef enum logic [1:0] {
    PC_KEEP,
    PC_INC,
    PC_JUMP,
    PC_PEND
  } pc_sel_e;

endpackage

// File: rtl/instruction_fetch_pc_next_sel.sv
// Combinational next-PC selector: hold, increment (wrapping), jump target or pending target.
module pc_next_sel
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  pc_sel_e           sel,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [ADDR_W-1:0] pending_target,
  output logic [ADDR_W-1:0] pc_next
);

  always_comb begin
    pc_next = pc;
    unique case (sel)
      PC_KEEP: pc_next = pc;
      PC_INC:  pc_next = pc + ADDR_W'(1);
      PC_JUMP: pc_next = jump_addr;
      PC_PEND: pc_next = pending_target;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction-fetch front end: owns PC and IR, reads program memory over req/ack
// and presents words to the control unit over valid/accept, with jump and halt.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEFAULT,
  parameter int          INSTR_W  = INSTR_W_DEFAULT,
  parameter int unsigned RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  input  logic               instr_accept,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  if_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  pend_tgt_q, pend_tgt_d;
  logic               halt_pend_q, halt_pend_d;
  logic               mem_req_q, mem_req_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  pc_sel_e            pc_sel;

  pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
    .sel            (pc_sel),
    .pc             (pc_q),
    .jump_addr      (jump_addr),
    .pending_target (pend_tgt_q),
    .pc_next        (pc_d)
  );

  always_comb begin
    state_d     = state_q;
    pc_sel      = PC_KEEP;
    ir_d        = ir_q;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
    halt_pend_d = halt_pend_q;
    unique case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_REQ;
          if (jump_en) pc_sel = PC_JUMP;
        end
      end
      S_REQ: begin
        // The read in flight always completes; jumps and halts only act at ack.
        if (mem_ack) begin
          pend_d = 1'b0;
          if (halt || halt_pend_q) begin
            state_d = S_HALTED;
          end else if (jump_en) begin
            pc_sel = PC_JUMP;
          end else if (pend_q) begin
            pc_sel = PC_PEND;
          end else begin
            ir_d    = mem_rdata;
            pc_sel  = PC_INC;
            state_d = S_HOLD;
          end
        end else if (halt) begin
          halt_pend_d = 1'b1;
        end else if (jump_en) begin
          pend_d     = 1'b1;
          pend_tgt_d = jump_addr;
        end
      end
      S_HOLD: begin
        if (halt) begin
          state_d = S_HALTED;
        end else begin
          if (jump_en) pc_sel = PC_JUMP;
          if (instr_accept) state_d = S_REQ;
        end
      end
      default: ;
    endcase

    mem_req_d = (state_d == S_REQ);
    valid_d   = (state_d == S_HOLD);
    halted_d  = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= PC_RST;
      ir_q        <= '0;
      pend_q      <= 1'b0;
      pend_tgt_q  <= '0;
      halt_pend_q <= 1'b0;
      mem_req_q   <= 1'b0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
      halt_pend_q <= halt_pend_d;
      mem_req_q   <= mem_req_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instruction = ir_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand-written corner sequences,
// and a randomized run checked against a transaction-level scoreboard.
module tb_instruction_fetch;

  localparam int AW = 8;
  localparam int IW = 16;

  logic          clk;
  logic          reset;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [IW-1:0] mem_rdata;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic          instr_accept;
  logic          jump_en;
  logic [AW-1:0] jump_addr;
  logic          halt;
  logic [AW-1:0] pc;
  logic          halted;

  int nvec = 0;
  int nerr = 0;

  instruction_fetch #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .instr_accept (instr_accept),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .halt         (halt),
    .pc           (pc),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return 16'h1000 + {8'h00, a};
  endfunction

  always_comb mem_rdata = mem_word(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic a, input logic acc, input logic j,
                      input logic [AW-1:0] ja, input logic h);
    @(negedge clk);
    mem_ack = a; instr_accept = acc; jump_en = j; jump_addr = ja; halt = h;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          ack, acc, jen;
    logic [AW-1:0] jaddr;
    logic          hlt;
    logic          req;
    logic [AW-1:0] addr;
    logic          vld;
    logic [IW-1:0] ir;
    logic [AW-1:0] pcv;
    logic          hltd;
  } vec_t;

  vec_t tbl [19];

  logic [IW-1:0] q[$];
  logic [AW-1:0] exp_addr;
  bit            req_jumped;
  int            delivered;
  logic          pre_req, pre_valid;
  logic [AW-1:0] pre_addr;
  logic [IW-1:0] pre_instr;

  initial begin
    // ack acc jen jaddr hlt | req addr vld ir pc halted
    tbl[0]  = '{0,1,0,8'h00,0, 1,8'h00,0,16'h0000,8'h00,0};
    tbl[1]  = '{0,1,0,8'h00,0, 1,8'h00,0,16'h0000,8'h00,0};
    tbl[2]  = '{1,1,0,8'h00,0, 0,8'h01,1,16'h1000,8'h01,0};
    tbl[3]  = '{0,1,0,8'h00,0, 1,8'h01,0,16'h1000,8'h01,0};
    tbl[4]  = '{0,1,0,8'h00,0, 1,8'h01,0,16'h1000,8'h01,0};
    tbl[5]  = '{1,1,0,8'h00,0, 0,8'h02,1,16'h1001,8'h02,0};
    tbl[6]  = '{0,1,0,8'h00,0, 1,8'h02,0,16'h1001,8'h02,0};
    tbl[7]  = '{0,1,0,8'h00,0, 1,8'h02,0,16'h1001,8'h02,0};
    tbl[8]  = '{1,1,0,8'h00,0, 0,8'h03,1,16'h1002,8'h03,0};
    tbl[9]  = '{0,1,0,8'h00,0, 1,8'h03,0,16'h1002,8'h03,0};
    tbl[10] = '{0,1,1,8'h40,0, 1,8'h03,0,16'h1002,8'h03,0};
    tbl[11] = '{1,1,0,8'h00,0, 1,8'h40,0,16'h1002,8'h40,0};
    tbl[12] = '{0,1,0,8'h00,0, 1,8'h40,0,16'h1002,8'h40,0};
    tbl[13] = '{1,1,0,8'h00,0, 0,8'h41,1,16'h1040,8'h41,0};
    tbl[14] = '{0,0,1,8'h20,0, 0,8'h20,1,16'h1040,8'h20,0};
    tbl[15] = '{0,0,1,8'h20,0, 0,8'h20,1,16'h1040,8'h20,0};
    tbl[16] = '{0,0,1,8'h20,0, 0,8'h20,1,16'h1040,8'h20,0};
    tbl[17] = '{0,1,0,8'h00,0, 1,8'h20,0,16'h1040,8'h20,0};
    tbl[18] = '{1,1,0,8'h00,0, 0,8'h21,1,16'h1020,8'h21,0};

    mem_ack = 0; instr_accept = 0; jump_en = 0; jump_addr = '0; halt = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst.mem_req", mem_req, 0);
    check("rst.mem_addr", mem_addr, 0);
    check("rst.instruction", instruction, 0);
    check("rst.instr_valid", instr_valid, 0);
    check("rst.pc", pc, 0);
    check("rst.halted", halted, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].ack, tbl[i].acc, tbl[i].jen, tbl[i].jaddr, tbl[i].hlt);
      check($sformatf("v%0d.mem_req", i), mem_req, tbl[i].req);
      check($sformatf("v%0d.mem_addr", i), mem_addr, tbl[i].addr);
      check($sformatf("v%0d.instr_valid", i), instr_valid, tbl[i].vld);
      check($sformatf("v%0d.instruction", i), instruction, tbl[i].ir);
      check($sformatf("v%0d.pc", i), pc, tbl[i].pcv);
      check($sformatf("v%0d.halted", i), halted, tbl[i].hltd);
    end

    // PC wrap from 8'hFF to 8'h00.
    step(0, 1, 1, 8'hFF, 0);
    check("wrap.req_addr", mem_addr, 8'hFF);
    step(1, 1, 0, 8'h00, 0);
    check("wrap.instruction", instruction, 16'h10FF);
    check("wrap.pc", pc, 8'h00);
    step(0, 1, 0, 8'h00, 0);
    check("wrap.mem_req", mem_req, 1);
    check("wrap.next_addr", mem_addr, 8'h00);

    // Halt while a read is in flight; ack arrives three cycles later.
    step(0, 0, 0, 8'h00, 1);
    check("halt.req_held0", mem_req, 1);
    check("halt.halted0", halted, 0);
    for (int k = 1; k < 3; k++) begin
      step(0, 1, 0, 8'h00, 0);
      check($sformatf("halt.req_held%0d", k), mem_req, 1);
      check($sformatf("halt.no_valid%0d", k), instr_valid, 0);
      check($sformatf("halt.not_yet%0d", k), halted, 0);
    end
    step(1, 1, 0, 8'h00, 0);
    check("halt.halted", halted, 1);
    check("halt.req_drop", mem_req, 0);
    check("halt.no_valid", instr_valid, 0);
    for (int k = 0; k < 5; k++) begin
      step(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 0);
      check($sformatf("halt.sticky%0d", k), halted, 1);
      check($sformatf("halt.idle_req%0d", k), mem_req, 0);
      check($sformatf("halt.idle_valid%0d", k), instr_valid, 0);
    end

    // Asynchronous reset in the middle of a request; a stray ack afterwards.
    reset = 1'b0;
    #1;
    check("arst.halted_clr", halted, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    step(0, 0, 0, 8'h00, 0);
    check("arst.in_req", mem_req, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst.mem_req", mem_req, 0);
    check("arst.pc", pc, 0);
    check("arst.instr_valid", instr_valid, 0);
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    check("arst.held_req", mem_req, 0);
    reset = 1'b1;
    step(1, 0, 0, 8'h00, 0);
    check("arst.stray_req", mem_req, 1);
    check("arst.stray_valid", instr_valid, 0);
    check("arst.stray_ir", instruction, 0);
    check("arst.stray_pc", pc, 0);

    // Randomized run against the scoreboard.
    mem_ack = 0; instr_accept = 0; jump_en = 0; jump_addr = '0; halt = 0;
    reset = 1'b0;
    #1;
    @(posedge clk);
    #1 reset = 1'b1;
    exp_addr = '0; req_jumped = 0; delivered = 0; q.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      mem_ack      = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      instr_accept = 1'($urandom_range(0, 1));
      jump_en      = ($urandom_range(0, 9) == 0);
      jump_addr    = 8'($urandom_range(0, 255));
      halt         = 1'b0;
      pre_req = mem_req; pre_addr = mem_addr; pre_valid = instr_valid; pre_instr = instruction;
      @(posedge clk);
      #1;
      if (pre_valid && instr_accept) begin
        if (q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL rnd.spurious_valid: got word %0h expected no word", pre_instr);
        end else begin
          check("rnd.accepted_word", pre_instr, q.pop_front());
        end
      end
      if (pre_req && mem_ack) begin
        if (!(jump_en || req_jumped)) begin
          check("rnd.fetch_addr", pre_addr, exp_addr);
          q.push_back(mem_word(pre_addr));
          exp_addr = pre_addr + 8'd1;
          check("rnd.pc_inc", pc, exp_addr);
          delivered++;
        end
        req_jumped = 0;
      end else if (pre_req && jump_en) begin
        req_jumped = 1;
      end
      if (jump_en) exp_addr = jump_addr;
      check("rnd.valid", instr_valid, 32'(q.size() != 0));
      if (instr_valid && q.size() != 0) check("rnd.ir", instruction, q[0]);
      check("rnd.req_valid_excl", mem_req & instr_valid, 0);
    end
    nvec++;
    if (delivered < 50) begin
      nerr++;
      $display("FAIL rnd.progress: got %0d words expected at least 50", delivered);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch front end for the 16-bit CPU. Owns the program counter and instruction register, and reads instruction words from program memory over a req/ack handshake. Presents each word to the control unit with a valid/accept handshake, and applies jump targets and halt requests. It supplies the `instruction` bus that the control unit decodes.

## Interface
Parameters:
- ADDR_W, 8, program-memory address width; PC wraps modulo 2^ADDR_W
- INSTR_W, 16, instruction word width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately on assertion
- mem_req  out  1  read request to program memory
- mem_addr  out  ADDR_W  read address; equals `pc` while mem_req=1
- mem_ack  in  1  memory completes the read; mem_rdata is valid in the same cycle
- mem_rdata  in  INSTR_W  read data
- instruction  out  INSTR_W  instruction register contents
- instr_valid  out  1  `instruction` holds an unconsumed word
- instr_accept  in  1  control unit consumes the presented word
- jump_en  in  1  redirect fetch to jump_addr
- jump_addr  in  ADDR_W  jump target
- halt  in  1  stop fetching; sticky until reset
- pc  out  ADDR_W  address of the next word to be fetched
- halted  out  1  unit is in S_HALTED

## Operation
State machine:
- S_IDLE: entered on reset release; moves to S_REQ on the next clock.
- S_REQ: mem_req=1, mem_addr=pc, held until mem_ack.
  - On ack with no pending jump: IR<=mem_rdata, pc<=pc+1 (wraps), go to S_HOLD.
  - On ack with pending jump: discard rdata, pc<=captured target, clear pending, stay in S_REQ.
- S_HOLD: instr_valid=1, mem_req=0. IR is stable until accepted.
  - On instr_accept: go to S_REQ.
  - If jump_en is high in the same cycle, also pc<=jump_addr.
- S_HALTED: mem_req=0, instr_valid=0, halted=1. Exit only via reset.

Jump rules:
- jump_en in S_REQ without ack: capture jump_addr into pending_target and set pending. The in-flight read is never aborted; mem_req stays high.
- jump_en and mem_ack in the same S_REQ cycle: discard rdata, pc<=jump_addr, stay in S_REQ.
- A later jump_en while pending is set overwrites pending_target (last wins).
- jump_en in S_HOLD without instr_accept: pc<=jump_addr; the presented IR word stays valid.
- jump_en in S_IDLE: pc<=jump_addr.

Halt rules:
- Priority per cycle: halt > jump_en > instr_accept.
- halt in S_IDLE or S_HOLD: go to S_HALTED next cycle; the presented word is dropped.
- halt in S_REQ: set halt_pending; mem_req stays high until mem_ack, then go to S_HALTED. rdata is discarded.
- An outstanding memory transaction always completes; there is no abort.

Arithmetic: PC increment is ADDR_W-bit unsigned. 2^ADDR_W−1 increments to 0.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, instruction=0, instr_valid=0, pc=RESET_PC, halted=0. Internal: state=S_IDLE, pending and halt_pending cleared.
- Latency with zero-wait memory (ack in the first req cycle): reset release → mem_req at cycle 1 → instr_valid at cycle 2.
- Throughput: one instruction per 2 cycles with zero-wait memory and accept asserted as soon as valid.
- Handshake outputs (mem_req, mem_addr, instr_valid, halted, instruction) are registered; none is combinationally dependent on inputs.
- mem_req deasserts the cycle after ack unless the FSM stays in S_REQ.
- Reset mid-transaction: the FSM returns to S_IDLE at once; any later stray mem_ack is ignored.

## Structure
- Shared state include, alongside the existing machine-state constants: S_IDLE, S_REQ, S_HOLD, S_HALTED, plus RESET_PC and ADDR_W defaults.
- Single module. PC next-value logic (increment / jump / pending target) is natural as sub-module `pc_next_sel`, which is combinational and instanced once.

## Test plan
- Sequential fetch: memory returns 16'h1000+addr with 1 wait cycle; accept always high → IR sequence 1000,1001,1002; pc 1,2,3; mem_req high 2 cycles per fetch.
- Jump during wait: jump_en=1, jump_addr=8'h40 in the first S_REQ cycle of the fetch from address 3 → word from 3 never becomes valid; next mem_addr=8'h40; next IR=1040.
- Hold and jump: instr_valid high, accept=0 for 3 cycles with jump_addr=8'h20 → IR stays unchanged; after accept, mem_addr=8'h20.
- Wrap-around: ADDR_W=8, pc=8'hFF fetched → pc becomes 8'h00 and the next mem_addr=8'h00.
- Halt with read in flight: halt pulsed while mem_req=1 and ack delayed 3 cycles → mem_req stays high until ack, instr_valid never rises, halted=1 the cycle after ack, and it stays set.
- Async reset mid-S_REQ: reset asserted low between clock edges → mem_req=0, pc=RESET_PC, instr_valid=0 immediately. A mem_ack arriving one cycle later has no effect.
